// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the core's load/store unit:
// order/RW encodings, request-entry packing, FSM states and the lane-merge helper.
package data_mem_responder_pkg;

    localparam logic [1:0] ORDER_BYTE    = 2'b00;
    localparam logic [1:0] ORDER_HALF    = 2'b01;
    localparam logic [1:0] ORDER_WORD    = 2'b10;
    localparam logic [1:0] ORDER_ILLEGAL = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic        rw;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic [13:0] tid;
        logic [31:0] addr;
        logic [31:0] data;
    } req_entry_t;

    localparam int REQ_ENTRY_W = $bits(req_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
`ifdef DATA_MEM_RESPONDER_WAIT_EN
        ,
        ST_WAIT   = 2'd3
`endif
    } fsm_state_t;

    // Byte-merge a 32-bit write into one lane of a 64-bit RAM entry.
    function automatic logic [63:0] merge_lane(
        input logic [63:0] old_entry,
        input logic        lane,
        input logic [3:0]  mask,
        input logic [31:0] wdata
    );
        logic [63:0] res;
        res = old_entry;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[(lane ? 32 : 0) + b * 8 +: 8] = wdata[b * 8 +: 8];
            end else begin
                res[(lane ? 32 : 0) + b * 8 +: 8] = old_entry[(lane ? 32 : 0) + b * 8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_req_fifo.sv
// Request queue for the data-memory responder: first-word-fall-through FIFO of packed
// request entries with registered full/empty/count flags.
module data_mem_req_fifo
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  req_entry_t               i_wdata,
    output req_entry_t               o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    req_entry_t        r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;
    logic [PW:0]       w_count_nxt;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    // Occupancy after this edge; flags are registered from it.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (PW + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (PW + 1)'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Pointers, count and flags; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (PW + 1)'(DEPTH));
            r_empty <= (w_count_nxt == (PW + 1)'(0));
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: queues requests and serves them in order
// from a 64-bit RAM. Define DATA_MEM_RESPONDER_WAIT_EN to add WAIT_CYCLES wait states.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MEM_DEPTH       = 1024,
    parameter int          WAIT_CYCLES     = 0,
    parameter logic [27:0] MMU_FLAGS_VALUE = 28'h0
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iDATA_REQ,
    output logic        oDATA_LOCK,
    input  logic [1:0]  iDATA_ORDER,
    input  logic [3:0]  iDATA_MASK,
    input  logic        iDATA_RW,
    input  logic [13:0] iDATA_TID,
    input  logic [1:0]  iDATA_MMUMOD,
    input  logic [31:0] iDATA_PDT,
    input  logic [31:0] iDATA_ADDR,
    input  logic [31:0] iDATA_DATA,
    output logic        oDATA_VALID,
    output logic        oDATA_PAGEFAULT,
    output logic [63:0] oDATA_DATA,
    output logic [27:0] oDATA_MMU_FLAGS
);

    localparam int          MAW       = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd8;

    fsm_state_t                   r_state;
    fsm_state_t                   w_state_nxt;
    fsm_state_t                   w_pop_state;
    req_entry_t                   w_entry_in;
    req_entry_t                   w_fifo_rdata;
    req_entry_t                   r_entry;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_do_access;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_fifo_count;
    logic                         w_fault;
    logic [MAW-1:0]               w_idx;
    logic [63:0]                  r_mem [MEM_DEPTH];
    logic                         r_valid;
    logic                         r_pagefault;
    logic [63:0]                  r_data;
    logic [27:0]                  r_mmu_flags;
    logic                         w_unused;

    assign w_entry_in = '{rw: iDATA_RW, order: iDATA_ORDER, mask: iDATA_MASK,
                          tid: iDATA_TID, addr: iDATA_ADDR, data: iDATA_DATA};
    assign w_push     = iDATA_REQ & ~w_fifo_full;
    assign oDATA_LOCK = w_fifo_full;

    data_mem_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .i_clk   (iCLOCK),
        .i_rst_n (inRESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry_in),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef DATA_MEM_RESPONDER_WAIT_EN
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [WCW-1:0] r_wait_cnt;

    assign w_pop_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;

    // Wait-state down-counter, loaded on every pop.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wait_cnt <= '0;
        end else if (w_pop) begin
            r_wait_cnt <= WCW'(WAIT_CYCLES - 1);
        end else if (r_state == ST_WAIT && r_wait_cnt != WCW'(0)) begin
            r_wait_cnt <= r_wait_cnt - WCW'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    assign w_unused = ^{iDATA_MMUMOD, iDATA_PDT, r_entry.tid, w_fifo_count};
`else
    assign w_pop_state = ST_ACCESS;
    assign w_unused    = ^{iDATA_MMUMOD, iDATA_PDT, r_entry.tid, w_fifo_count,
                           (WAIT_CYCLES != 0)};
`endif

    // Next state and per-cycle controls.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_do_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_pop_state;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_do_access = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_pop_state;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef DATA_MEM_RESPONDER_WAIT_EN
            ST_WAIT: begin
                if (r_wait_cnt == WCW'(0)) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holds the request being served from pop until its response is registered.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_entry <= '0;
        end else if (w_pop) begin
            r_entry <= w_fifo_rdata;
        end else begin
            r_entry <= r_entry;
        end
    end

    assign w_fault = ({1'b0, r_entry.addr} >= MEM_BYTES) || (r_entry.order == ORDER_ILLEGAL);
    assign w_idx   = r_entry.addr[3 +: MAW];

    // RAM write port; contents survive reset.
    always_ff @(posedge iCLOCK) begin
        if (w_do_access && r_entry.rw == RW_WRITE && !w_fault) begin
            r_mem[w_idx] <= merge_lane(r_mem[w_idx], r_entry.addr[2], r_entry.mask, r_entry.data);
        end
    end

    // Response registers: loaded by ACCESS, visible for exactly the RESP cycle.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_valid     <= 1'b0;
            r_pagefault <= 1'b0;
            r_data      <= 64'd0;
            r_mmu_flags <= 28'd0;
        end else if (w_do_access) begin
            r_valid     <= 1'b1;
            r_pagefault <= w_fault;
            r_data      <= (!w_fault && r_entry.rw == RW_READ) ? r_mem[w_idx] : 64'd0;
            r_mmu_flags <= MMU_FLAGS_VALUE;
        end else begin
            r_valid     <= 1'b0;
            r_pagefault <= 1'b0;
            r_data      <= 64'd0;
            r_mmu_flags <= 28'd0;
        end
    end

    assign oDATA_VALID     = r_valid;
    assign oDATA_PAGEFAULT = r_pagefault;
    assign oDATA_DATA      = r_data;
    assign oDATA_MMU_FLAGS = r_mmu_flags;

endmodule
